card_shoe: RTL

CARD_SHOE -- requirements
Module: card_shoe

---
 rtl/card_shoe.sv | 104 ++++++++++
 1 files changed

// File: rtl/card_shoe.sv
// Single 52-card shoe: rank counters drained by an LFSR-seeded pointer that walks to the next non-empty rank.
// One card per REQ rising edge, 2..11 clocks after REQ is sampled; REQ must drop before the next draw.
module card_shoe (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_shuffle,
    input  logic       i_req,
    output logic [3:0] o_do,
    output logic       o_valid,
    output logic       o_empty,
    output logic [5:0] o_left
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEEK = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_lfsr;
    logic       r_req;
    logic       r_req_d;
    logic [3:0] r_ptr;
    // slots 0..7 hold ranks 0..7, slot 8 holds rank 9; the ten-valued rank has its own wider counter
    logic [2:0] r_cnt [0:8];
    logic [4:0] r_tens;
    logic [5:0] r_left;
    logic [3:0] r_do;
    logic       r_valid;

    logic       w_draw;
    logic       w_lfsr_fb;
    logic [3:0] w_start_ptr;
    logic [3:0] w_slot;
    logic       w_avail;
    logic [3:0] w_ptr_next;

    assign w_draw      = r_req & ~r_req_d;
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_start_ptr = (r_lfsr[3:0] >= 4'd10) ? (r_lfsr[3:0] - 4'd6) : r_lfsr[3:0];
    assign w_slot      = (r_ptr == 4'd9) ? 4'd8 : r_ptr;
    assign w_avail     = (r_ptr == 4'd8) ? (r_tens != 5'd0) : (r_cnt[w_slot] != 3'd0);
    assign w_ptr_next  = (r_ptr == 4'd9) ? 4'd0 : (r_ptr + 4'd1);

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state <= S_IDLE;
            r_lfsr  <= 8'hA5;
            r_req   <= 1'b0;
            r_req_d <= 1'b0;
            r_ptr   <= 4'd0;
            for (int i = 0; i < 9; i++) r_cnt[i] <= 3'd4;
            r_tens  <= 5'd16;
            r_left  <= 6'd52;
            r_do    <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_req   <= i_req;
            r_req_d <= r_req;
            if (i_shuffle) begin
                r_state <= S_IDLE;
                r_lfsr  <= 8'hA5;
                for (int i = 0; i < 9; i++) r_cnt[i] <= 3'd4;
                r_tens  <= 5'd16;
                r_left  <= 6'd52;
                r_do    <= 4'd0;
                r_valid <= 1'b0;
            end else begin
                r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};
                r_valid <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_draw && (r_left != 6'd0)) begin
                            r_ptr   <= w_start_ptr;
                            r_state <= S_SEEK;
                        end
                    end
                    S_SEEK: begin
                        // a non-empty deck guarantees a hit within one lap of the ten ranks
                        if (w_avail) begin
                            if (r_ptr == 4'd8) r_tens <= r_tens - 5'd1;
                            else               r_cnt[w_slot] <= r_cnt[w_slot] - 3'd1;
                            r_left  <= r_left - 6'd1;
                            r_do    <= r_ptr + 4'd2;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end else begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                    S_HOLD: begin
                        if (!r_req) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_do    = r_do;
    assign o_valid = r_valid;
    assign o_left  = r_left;
    assign o_empty = (r_left == 6'd0);

endmodule
